pipe_fetch_hs: RTL and testbench

Fetch-to-decode pipeline register with a valid/ready handshake, flush-to-bubble and an optional two-entry skid buffer. It sits between instruction memory/PC logic and the decode stage. It carries the instruction, PC and PC+4 into decode, and drives the destination-register field. It replaces the free-running fetch register, so fetch and decode can stall independently without losing or duplicating an instruction.

---
 rtl/pipe_fetch_hs_pkg.sv | 25 ++
 rtl/pipe_fetch_hs_if.sv | 30 +++
 rtl/pipe_fetch_hs_skid.sv | 31 +++
 rtl/pipe_fetch_hs.sv | 130 +++++++++++++
 tb/tb_pipe_fetch_hs.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/pipe_fetch_hs_pkg.sv
// Shared types and constants for the fetch-to-decode pipeline register.
// Build option: PIPE_FETCH_SKID_EN selects the two-entry skid variant.
package pipe_pkg;

    localparam int unsigned PF_ADDRESS_WIDTH = 32;
    localparam int unsigned PF_DATA_WIDTH    = 32;
    localparam int unsigned PF_WRITE_WIDTH   = 5;

    // addi x0,x0,0 : bubble instruction shown whenever decode sees no entry
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [PF_DATA_WIDTH-1:0]    instr;
        logic [PF_ADDRESS_WIDTH-1:0] pc;
        logic [PF_ADDRESS_WIDTH-1:0] pcplus4;
        logic [PF_WRITE_WIDTH-1:0]   rdidx;
    } fetch_payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pipe_fetch_hs_if.sv
// Fetch/decode handshake bundle. The stage uses the slave view; the
// surrounding fetch and decode logic uses the master view.
interface pipe_fetch_hs_if #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned WRITE_WIDTH   = 5
) ();
    logic                     validf;
    logic                     readyf;
    logic [DATA_WIDTH-1:0]    rd;
    logic [ADDRESS_WIDTH-1:0] pcf;
    logic [ADDRESS_WIDTH-1:0] pcplus4f;
    logic                     flushd;
    logic                     validd;
    logic                     readyd;
    logic [DATA_WIDTH-1:0]    instrd;
    logic [ADDRESS_WIDTH-1:0] pcd;
    logic [ADDRESS_WIDTH-1:0] pcplus4d;
    logic [WRITE_WIDTH-1:0]   rdd;

    modport slave (
        input  validf, rd, pcf, pcplus4f, flushd, readyd,
        output readyf, validd, instrd, pcd, pcplus4d, rdd
    );

    modport master (
        output validf, rd, pcf, pcplus4f, flushd, readyd,
        input  readyf, validd, instrd, pcd, pcplus4d, rdd
    );
endinterface

// File: rtl/pipe_fetch_hs_skid.sv
// Generic single-payload holding register with load and clear.
// Clear rewrites only the bits selected by CLR_MASK, so callers can
// bubble one field while the rest of the payload holds.
module pipe_skid #(
    parameter int unsigned     WIDTH    = 8,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter logic [WIDTH-1:0] CLR_MASK = '1,
    parameter logic [WIDTH-1:0] CLR_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_q;

    // payload register: clear beats load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= RST_VAL;
        end else if (i_clear) begin
            r_q <= (r_q & ~CLR_MASK) | (CLR_VAL & CLR_MASK);
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/pipe_fetch_hs.sv
// Fetch-to-decode pipeline register with valid/ready handshake and flush.
// Build option PIPE_FETCH_SKID_EN: adds a skid register and FULL state so
// readyf is a pure register decode; otherwise readyf = !validd || readyd.
module pipe_fetch_hs
    import pipe_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned WRITE_WIDTH   = 5,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(pipe_pkg::NOP_INSTR)
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_fetch_hs_if.slave   bus
);
    localparam int unsigned TAIL_W = 2 * ADDRESS_WIDTH + WRITE_WIDTH;
    localparam int unsigned PW     = DATA_WIDTH + TAIL_W;
    localparam logic [PW-1:0] MAIN_RST  = {NOP_INSTR, {TAIL_W{1'b0}}};
    localparam logic [PW-1:0] MAIN_MASK = {{DATA_WIDTH{1'b1}}, {TAIL_W{1'b0}}};

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic         w_validd;
    logic         w_in;
    logic         w_out;
    logic         w_main_ld;
    logic [PW-1:0] w_main_d;
    logic [PW-1:0] w_main_q;
    logic [PW-1:0] w_in_pay;

    assign w_in_pay = {bus.rd, bus.pcf, bus.pcplus4f, bus.rd[7 +: WRITE_WIDTH]};
    assign w_validd = (r_state != EMPTY);
    assign w_in     = bus.validf && bus.readyf && !bus.flushd;
    assign w_out    = w_validd && bus.readyd;

`ifdef PIPE_FETCH_SKID_EN
    logic          w_skid_ld;
    logic [PW-1:0] w_skid_q;

    assign bus.readyf = (r_state != FULL);
`else
    assign bus.readyf = !w_validd || bus.readyd;
`endif

    // next-state and register-load decode; flush overrides every event
    always_comb begin
        w_state_nxt = r_state;
        w_main_ld   = 1'b0;
        w_main_d    = w_in_pay;
`ifdef PIPE_FETCH_SKID_EN
        w_skid_ld   = 1'b0;
`endif
        if (bus.flushd) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in) begin
                        w_state_nxt = BUSY;
                        w_main_ld   = 1'b1;
                    end
                end
                BUSY: begin
                    if (w_in && w_out) begin
                        w_main_ld = 1'b1;
`ifdef PIPE_FETCH_SKID_EN
                    end else if (w_in) begin
                        w_state_nxt = FULL;
                        w_skid_ld   = 1'b1;
`endif
                    end else if (w_out) begin
                        w_state_nxt = EMPTY;
                    end
                end
`ifdef PIPE_FETCH_SKID_EN
                FULL: begin
                    if (w_out) begin
                        w_state_nxt = BUSY;
                        w_main_ld   = 1'b1;
                        w_main_d    = w_skid_q;
                    end
                end
`endif
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    pipe_skid #(
        .WIDTH    (PW),
        .RST_VAL  (MAIN_RST),
        .CLR_MASK (MAIN_MASK),
        .CLR_VAL  (MAIN_RST)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_main_ld),
        .i_clear (bus.flushd),
        .i_d     (w_main_d),
        .o_q     (w_main_q)
    );

`ifdef PIPE_FETCH_SKID_EN
    pipe_skid #(
        .WIDTH    (PW),
        .RST_VAL  ('0),
        .CLR_MASK ('1),
        .CLR_VAL  ('0)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_skid_ld),
        .i_clear (bus.flushd),
        .i_d     (w_in_pay),
        .o_q     (w_skid_q)
    );
`endif

    assign bus.validd = w_validd;
    assign {bus.instrd, bus.pcd, bus.pcplus4d, bus.rdd} = w_main_q;
endmodule

// File: tb/tb_pipe_fetch_hs.sv
// Directed bench for pipe_fetch_hs with a payload scoreboard queue.
// Adapts readyf expectations to PIPE_FETCH_SKID_EN.
module tb_pipe_fetch_hs;
    import pipe_pkg::*;

`ifdef PIPE_FETCH_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_fetch_hs_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .WRITE_WIDTH(5)) bus ();

    pipe_fetch_hs #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .WRITE_WIDTH   (5),
        .NOP_INSTR     (32'h0000_0013)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned    n_cmp = 0;
    int unsigned    n_err = 0;
    fetch_payload_t q[$];
    fetch_payload_t last_head;

    function automatic fetch_payload_t mk(input logic [31:0] ins, input logic [31:0] pc);
        fetch_payload_t p;
        p.instr   = ins;
        p.pc      = pc;
        p.pcplus4 = pc + 32'd4;
        p.rdidx   = ins[11:7];
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        q.delete();
        last_head = mk(32'h0000_0013, 32'h0);
        last_head.pcplus4 = '0;
        last_head.rdidx   = '0;
    endtask

    // one cycle: drive at posedge+1, check at negedge, update model at posedge
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic rdy, input logic fl, output logic acc);
        logic           exp_rf;
        fetch_payload_t h;
        bus.validf   = v;
        bus.rd       = ins;
        bus.pcf      = pc;
        bus.pcplus4f = pc + 32'd4;
        bus.readyd   = rdy;
        bus.flushd   = fl;
        @(negedge clk);
        exp_rf = SKID ? (q.size() < 2) : (q.size() == 0 || rdy);
        chk("readyf", 64'(bus.readyf), 64'(exp_rf));
        chk("validd", 64'(bus.validd), 64'(q.size() != 0));
        h = (q.size() != 0) ? q[0] : last_head;
        chk("instrd",   64'(bus.instrd),   64'(h.instr));
        chk("pcd",      64'(bus.pcd),      64'(h.pc));
        chk("pcplus4d", 64'(bus.pcplus4d), 64'(h.pcplus4));
        chk("rdd",      64'(bus.rdd),      64'(h.rdidx));
        @(posedge clk);
        acc = v && exp_rf && !fl;
        if (fl) begin
            q.delete();
            last_head.instr = 32'h0000_0013;
        end else begin
            if (q.size() != 0 && rdy) void'(q.pop_front());
            if (acc) q.push_back(mk(ins, pc));
        end
        if (q.size() != 0) last_head = q[0];
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_validd"},   64'(bus.validd),   64'd0);
        chk({tag, "_instrd"},   64'(bus.instrd),   64'h13);
        chk({tag, "_pcd"},      64'(bus.pcd),      64'd0);
        chk({tag, "_pcplus4d"}, 64'(bus.pcplus4d), 64'd0);
        chk({tag, "_rdd"},      64'(bus.rdd),      64'd0);
        chk({tag, "_readyf"},   64'(bus.readyf),   64'd1);
    endtask

    initial begin
        logic        acc;
        logic [31:0] cur_pc;
        logic [31:0] cur_ins;
        bus.validf = 0; bus.rd = '0; bus.pcf = '0; bus.pcplus4f = '0;
        bus.readyd = 0; bus.flushd = 0;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // idle after reset
        step(0, 32'h0, 32'h0, 1, 0, acc);

        // streaming at full rate
        step(1, 32'h0050_0093, 32'h0, 1, 0, acc);
        step(1, 32'h0020_8133, 32'h4, 1, 0, acc);
        step(1, 32'h0031_01b3, 32'h8, 1, 0, acc);
        step(0, 32'h0, 32'h0, 1, 0, acc);
        step(0, 32'h0, 32'h0, 1, 0, acc);

        // back-pressure: offer three, fetch holds an unaccepted one
        cur_pc = 32'h10; cur_ins = 32'h00a0_0513;
        for (int i = 0; i < 3; i++) begin
            step(1, cur_ins, cur_pc, 0, 0, acc);
            if (acc) begin cur_pc += 4; cur_ins += 32'h80; end
        end
        for (int i = 0; i < 5; i++) begin
            step((cur_pc < 32'h1c) ? 1'b1 : 1'b0, cur_ins, cur_pc, 1, 0, acc);
            if (acc) begin cur_pc += 4; cur_ins += 32'h80; end
        end

        // flush while full (or busy) with a new instruction offered
        step(1, 32'h0110_0593, 32'h20, 0, 0, acc);
        step(1, 32'h0120_0613, 32'h24, 0, 0, acc);
        step(1, 32'h0130_0693, 32'h28, 0, 1, acc);
        step(0, 32'h0, 32'h0, 1, 0, acc);
        step(0, 32'h0, 32'h0, 1, 0, acc);

        // asynchronous reset while holding entries
        step(1, 32'h0140_0713, 32'h30, 0, 0, acc);
        step(1, 32'h0150_0793, 32'h34, 0, 0, acc);
        bus.validf = 0;
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async");
        reset_model();
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(0, 32'h0, 32'h0, 1, 0, acc);

        if (!SKID) begin
            // combinational readyf from readyd while an entry is held
            step(1, 32'h0160_0813, 32'h40, 0, 0, acc);
            bus.validf = 0;
            bus.readyd = 0;
            #1 chk("comb_readyf_lo", 64'(bus.readyf), 64'd0);
            bus.readyd = 1;
            #1 chk("comb_readyf_hi", 64'(bus.readyf), 64'd1);
        end

        // random traffic with occasional flushes
        cur_pc = 32'h100; cur_ins = $urandom;
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 3) != 0), cur_ins, cur_pc,
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), acc);
            if (acc) begin cur_pc += 4; cur_ins = $urandom; end
        end
        for (int i = 0; i < 3; i++) step(0, 32'h0, 32'h0, 1, 0, acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
